// File: rtl/circle_buf_reader.sv
// rtl/circle_buf_reader.sv - read-side sweep engine for the circular capture buffer
// Sweeps the buffer once per captured frame and re-emits words as a framed valid/ready stream.
module circle_buf_reader #(
  parameter int aw = 6,
  parameter int dw = 16,
  parameter int rl = 1,
  parameter int fd = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          cont,
  input  logic          data_gate,
  output logic [aw-1:0] addr_r,
  output logic          stb_r,
  input  logic [dw-1:0] data_r,
  input  logic          trig_out,
  output logic [dw-1:0] o_data,
  output logic          o_trig,
  output logic          o_sof,
  output logic          o_eof,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          abort_err
);

  localparam int ew = dw + 3;
  localparam int pw = (fd > 1) ? $clog2(fd) : 1;
  localparam int cw = $clog2(fd + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [aw-1:0] addr_q;
  logic          armed_q;
  logic          abort_q;
  logic          done_q;
  logic [15:0]   count_q;

  // Per in-flight read: valid, first-address and last-address flags
  logic [rl:1]   pv_q;
  logic [rl:1]   pf_q;
  logic [rl:1]   pl_q;

  logic [ew-1:0] mem_q [fd];
  logic [pw-1:0] wr_q, wr_d;
  logic [pw-1:0] rd_q, rd_d;
  logic [cw-1:0] occ_q, occ_d;

  int            inflight;
  logic          wr_en;
  logic          rd_en;
  logic          last_addr;

  function automatic logic [pw-1:0] bump(input logic [pw-1:0] p);
    return (p == pw'(fd - 1)) ? '0 : p + pw'(1);
  endfunction

  always_comb begin
    inflight = 0;
    for (int i = 1; i <= rl; i++) inflight += int'(pv_q[i]);
  end

  assign last_addr = (addr_q == {aw{1'b1}});
  // Credit check covers both buffered words and reads still in the buffer pipeline
  assign stb_r     = (state_q == READ) && data_gate && ((int'(occ_q) + inflight) < fd);
  assign wr_en     = pv_q[rl];
  assign o_valid   = (occ_q != '0);
  assign rd_en     = o_valid && o_ready;

  assign {o_data, o_trig, o_sof, o_eof} = o_valid ? mem_q[rd_q] : '0;

  assign addr_r      = addr_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign abort_err   = abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[1] <= stb_r;
      pf_q[1] <= (addr_q == '0);
      pl_q[1] <= last_addr;
      for (int i = 2; i <= rl; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (wr_en) wr_d = bump(wr_q);
    if (rd_en) rd_d = bump(rd_q);
    if (wr_en && !rd_en) occ_d = occ_q + cw'(1);
    else if (!wr_en && rd_en) occ_d = occ_q - cw'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {data_r, trig_out, pf_q[rl], pl_q[rl]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      armed_q <= 1'b1;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && data_gate && armed_q) begin
            state_q <= READ;
            addr_q  <= '0;
            armed_q <= 1'b0;
          end else if (!data_gate) begin
            armed_q <= 1'b1;
          end
        end
        READ, DRAIN: begin
          // Losing the gate abandons the sweep; already-fetched words still drain out
          if (!data_gate) begin
            abort_q <= 1'b1;
            armed_q <= 1'b0;
            addr_q  <= '0;
            state_q <= IDLE;
          end else if (state_q == READ) begin
            if (stb_r) begin
              addr_q <= addr_q + aw'(1);
              if (last_addr) state_q <= DRAIN;
            end
          end else if (occ_q == '0 && inflight == 0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            count_q <= count_q + 16'd1;
          end
        end
        DONE: begin
          armed_q <= cont;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_buf_reader.sv
// tb/tb_circle_buf_reader.sv - self-checking bench for circle_buf_reader (rl=1 and rl=2 side by side)
module tb_circle_buf_reader;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int NW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, cont, data_gate, o_ready, rand_ready;
  int   base, trig_addr;

  logic [AW-1:0] addr_r [2];
  logic          stb_r [2];
  logic [DW-1:0] data_r [2];
  logic          trig_out [2];
  logic [DW-1:0] o_data [2];
  logic          o_trig [2], o_sof [2], o_eof [2], o_valid [2];
  logic          frame_done [2], abort_err [2];
  logic [15:0]   frame_count [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    circle_buf_reader #(.aw(AW), .dw(DW), .rl(g + 1), .fd(FD)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .cont(cont), .data_gate(data_gate),
      .addr_r(addr_r[g]), .stb_r(stb_r[g]), .data_r(data_r[g]), .trig_out(trig_out[g]),
      .o_data(o_data[g]), .o_trig(o_trig[g]), .o_sof(o_sof[g]), .o_eof(o_eof[g]),
      .o_valid(o_valid[g]), .o_ready(o_ready), .frame_done(frame_done[g]),
      .frame_count(frame_count[g]), .abort_err(abort_err[g]));
  end

  // Buffer model: word at address A holds base+A, trigger marks address trig_addr
  logic [DW-1:0] s1_d [2], s2_d [2];
  logic          s1_t [2], s2_t [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (stb_r[k]) begin
        s1_d[k] <= DW'(base + int'(addr_r[k]));
        s1_t[k] <= (int'(addr_r[k]) == trig_addr);
      end
      s2_d[k] <= s1_d[k];
      s2_t[k] <= s1_t[k];
    end
  end
  assign data_r[0]   = s1_d[0];
  assign trig_out[0] = s1_t[0];
  assign data_r[1]   = s2_d[1];
  assign trig_out[1] = s2_t[1];

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [DW+2:0] sbq [2][$];
  logic [DW+3:0] held [2];
  logic          stall [2];
  int issued [2], accepted [2], exp_addr [2];
  int stb_cnt [2], beat_cnt [2], sof_cnt [2], eof_cnt [2], trig_cnt [2], trig_idx [2];
  int done_cnt [2], first_stb [2], last_stb [2], first_val [2], sof_data [2], eof_data [2];

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[rl=%0d]: got %0h, expected %0h", name, k + 1, act, exp);
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      stb_cnt[k] = 0; beat_cnt[k] = 0; sof_cnt[k] = 0; eof_cnt[k] = 0;
      trig_cnt[k] = 0; trig_idx[k] = -1; done_cnt[k] = 0;
      first_stb[k] = -1; last_stb[k] = -1; first_val[k] = -1;
      sof_data[k] = -1; eof_data[k] = -1; exp_addr[k] = 0;
    end
  endtask

  // Per-cycle compare: every strobe must yield exactly one word, in order, with its flags
  task automatic sample();
    logic [DW+2:0] e;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        sbq[k].delete();
        issued[k] = 0; accepted[k] = 0; exp_addr[k] = 0; stall[k] = 1'b0;
      end else begin
        if (stb_r[k]) begin
          chk("stb_addr", k, addr_r[k], exp_addr[k]);
          exp_addr[k] = (exp_addr[k] + 1) % NW;
          e = {DW'(base + int'(addr_r[k])), int'(addr_r[k]) == trig_addr,
               addr_r[k] == '0, int'(addr_r[k]) == NW - 1};
          sbq[k].push_back(e);
          stb_cnt[k]++; issued[k]++;
          if (first_stb[k] < 0) first_stb[k] = cyc;
          last_stb[k] = cyc;
        end
        chk("outstanding_le_fd", k, (issued[k] - accepted[k]) <= FD, 1);
        if (stall[k])
          chk("held_stable", k, {o_valid[k], o_data[k], o_trig[k], o_sof[k], o_eof[k]}, held[k]);
        if (o_valid[k] && first_val[k] < 0) first_val[k] = cyc;
        if (o_valid[k] && o_ready) begin
          if (sbq[k].size() == 0) chk("beat_unexpected", k, 1, 0);
          else chk("beat", k, {o_data[k], o_trig[k], o_sof[k], o_eof[k]}, sbq[k].pop_front());
          if (o_sof[k]) begin sof_cnt[k]++; sof_data[k] = int'(o_data[k]); end
          if (o_eof[k]) begin eof_cnt[k]++; eof_data[k] = int'(o_data[k]); end
          if (o_trig[k]) begin trig_cnt[k]++; trig_idx[k] = beat_cnt[k]; end
          beat_cnt[k]++; accepted[k]++;
        end
        stall[k] = o_valid[k] && !o_ready;
        held[k]  = {o_valid[k], o_data[k], o_trig[k], o_sof[k], o_eof[k]};
        if (frame_done[k]) done_cnt[k]++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    o_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (!(done_cnt[0] >= target && done_cnt[1] >= target) && n < limit) begin tick(); n++; end
    for (int k = 0; k < 2; k++) chk("wait_frame_done", k, done_cnt[k] >= target, 1);
  endtask

  task automatic wait_stb(input int target, input int limit);
    int n = 0;
    while (stb_cnt[0] < target && n < limit) begin tick(); n++; end
    chk("wait_strobes", 0, stb_cnt[0] >= target, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, k, o_valid[k], 0);
      chk({tag, "_stb"}, k, stb_r[k], 0);
      chk({tag, "_addr"}, k, addr_r[k], 0);
      chk({tag, "_data"}, k, o_data[k], 0);
      chk({tag, "_flags"}, k, {o_trig[k], o_sof[k], o_eof[k], frame_done[k]}, 0);
      chk({tag, "_fcount"}, k, frame_count[k], 0);
      chk({tag, "_abort"}, k, abort_err[k], 0);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cont = 1'b0; data_gate = 1'b0; o_ready = 1'b1;
    rand_ready = 1'b0; base = 100; trig_addr = 1000;
    for (int k = 0; k < 2; k++) begin stall[k] = 1'b0; issued[k] = 0; accepted[k] = 0; end
    clear_stats();
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Basic frame, both read latencies
    clear_stats(); enable = 1'b1; data_gate = 1'b1;
    wait_done(1, 400);
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s1_strobes", k, stb_cnt[k], 64);
      chk("s1_strobe_span", k, last_stb[k] - first_stb[k], 63);
      chk("s1_beats", k, beat_cnt[k], 64);
      chk("s1_sof", k, {sof_cnt[k], sof_data[k]}, {32'd1, 32'd100});
      chk("s1_eof", k, {eof_cnt[k], eof_data[k]}, {32'd1, 32'd163});
      chk("s1_trig", k, trig_cnt[k], 0);
      chk("s1_latency", k, first_val[k] - first_stb[k], k + 2);
      chk("s1_done", k, done_cnt[k], 1);
      chk("s1_fcount", k, frame_count[k], 1);
    end

    // cont=0, gate held high: no second frame
    repeat (100) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s6a_no_rearm_strobes", k, stb_cnt[k], 64);
      chk("s6a_no_rearm_done", k, done_cnt[k], 1);
    end
    data_gate = 1'b0;
    repeat (3) tick();

    // Backpressure with a trigger at address 32
    clear_stats(); base = 500; trig_addr = 32; rand_ready = 1'b1; data_gate = 1'b1;
    wait_done(1, 2000);
    rand_ready = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s2_beats", k, beat_cnt[k], 64);
      chk("s2_sof", k, {sof_cnt[k], sof_data[k]}, {32'd1, 32'd500});
      chk("s2_eof", k, {eof_cnt[k], eof_data[k]}, {32'd1, 32'd563});
      chk("s4_trig_count", k, trig_cnt[k], 1);
      chk("s4_trig_index", k, trig_idx[k], 32);
      chk("s2_pending", k, sbq[k].size(), 0);
      chk("s2_fcount", k, frame_count[k], 2);
    end
    data_gate = 1'b0;
    repeat (3) tick();

    // Abort after 20 strobes
    clear_stats(); base = 0; trig_addr = 1000; data_gate = 1'b1;
    wait_stb(20, 200);
    data_gate = 1'b0;
    repeat (20) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s5_strobes_le20", k, stb_cnt[k] <= 20, 1);
      chk("s5_beats_eq_strobes", k, beat_cnt[k], stb_cnt[k]);
      chk("s5_sof", k, sof_cnt[k], 1);
      chk("s5_no_eof", k, eof_cnt[k], 0);
      chk("s5_no_done", k, done_cnt[k], 0);
      chk("s5_abort_err", k, abort_err[k], 1);
      chk("s5_fcount", k, frame_count[k], 2);
      chk("s5_pending", k, sbq[k].size(), 0);
    end

    // Full frame after the abort
    clear_stats(); base = 200; data_gate = 1'b1;
    wait_done(1, 400);
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s5b_beats", k, beat_cnt[k], 64);
      chk("s5b_eof", k, {eof_cnt[k], eof_data[k]}, {32'd1, 32'd263});
      chk("s5b_fcount", k, frame_count[k], 3);
      chk("s5b_abort_sticky", k, abort_err[k], 1);
    end
    data_gate = 1'b0;
    repeat (3) tick();

    // Reset mid-READ
    clear_stats(); base = 0; data_gate = 1'b1;
    wait_stb(10, 200);
    reset = 1'b1;
    tick();
    check_zero_outputs("s6c_reset");
    cont = 1'b1;
    reset = 1'b0;

    // cont=1, gate high: back-to-back frames
    clear_stats(); base = 300;
    for (int f = 1; f <= 3; f++) begin
      wait_done(f, 400);
      for (int k = 0; k < 2; k++) chk("s6b_fcount", k, frame_count[k], f);
    end
    repeat (10) tick();
    enable = 1'b0;
    wait_done(4, 400);
    repeat (80) tick();
    for (int k = 0; k < 2; k++) begin
      chk("s6b_done_total", k, done_cnt[k], 4);
      chk("s6b_fcount_final", k, frame_count[k], 4);
      chk("s6b_strobes", k, stb_cnt[k], 256);
      chk("s6b_beats", k, beat_cnt[k], 256);
      chk("s6b_eof", k, eof_cnt[k], 4);
      chk("s6b_pending", k, sbq[k].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
